decode_stage: RTL

//  ID stage of the MIPS R2000 pipeline, directly downstream of IF. Consumes pc_out/inst_out from IF.

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/decode_reg_file.sv | 51 +++++
 rtl/decode_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS R2000 ID stage: ALU operation
// encoding, opcode/funct values, the control bundle carried into ID/EX,
// and the all-zero bubble.
package mips_pkg;

  // Exception handler address; the IF mux owns the actual redirect.
  localparam logic [31:0] EXC_VECTOR = 32'h4000_0040;
  localparam int          NREGS      = 32;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_ADDU = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SUBU = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_NOR  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_SLL  = 4'd11,
    ALU_SRL  = 4'd12,
    ALU_SRA  = 4'd13,
    ALU_LUI  = 4'd14
  } alu_op_t;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Control bundle handed to EX alongside the datapath values.
  typedef struct packed {
    alu_op_t alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
  } ctrl_t;

  // A bubble does nothing downstream: no writes, no memory access.
  localparam ctrl_t BUBBLE = ctrl_t'(10'd0);

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_reg_file.sv
// 32x32 register file for the ID stage: two combinational read ports,
// one synchronous write port, r0 hardwired to zero, and a same-cycle
// writeback bypass so ID sees a value written in the current cycle.
import mips_pkg::*;

module decode_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [31:0] r_regs [0:NREGS-1];
  logic        w_wb_live;

  // A writeback to r0 is discarded everywhere, including the bypass.
  assign w_wb_live = wb_we && (wb_addr != 5'd0);

  // Storage: cleared on reset, written on the clock edge; r0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wb_live) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Read ports: r0 reads zero, then bypass, then stored value.
  always_comb begin
    rs_data = r_regs[rs_addr];
    rt_data = r_regs[rt_addr];
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (w_wb_live && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (w_wb_live && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS R2000 ID stage: instruction decode, load-use hazard detection,
// branch/jump resolution (single delay slot, no flush), reserved-instruction
// exception with a one-instruction squash, and the ID/EX pipeline register.
import mips_pkg::*;

module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        hold_pc,
  output logic        hold_if,
  output logic        br,
  output logic [31:0] pc_branch,
  output logic        except,
  output logic [31:0] epc,
  output logic [31:0] id_pc,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [3:0]  id_alu_op,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_mem_to_reg,
  output logic        id_alu_src,
  output logic        id_reg_dst
);

  // Instruction fields
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_sext;

  // Register file read data (already bypassed)
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  // Decode results
  ctrl_t       w_ctrl;
  logic        w_valid;
  logic        w_is_branch;
  logic        w_br_taken;
  logic        w_uses_rt;
  logic [31:0] w_imm;
  logic [31:0] w_target;

  // Stage control
  logic        w_stall;
  logic        w_bubble;
  logic        w_except;
  logic        w_br;

  // State
  logic        r_squash;
  logic [31:0] r_epc;
  ctrl_t       r_ctrl;
  logic [31:0] r_pc;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;

  assign w_op       = inst_in[31:26];
  assign w_rs       = inst_in[25:21];
  assign w_rt       = inst_in[20:16];
  assign w_rd       = inst_in[15:11];
  assign w_funct    = inst_in[5:0];
  assign w_imm_sext = sext16(inst_in[15:0]);

  decode_reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (w_rs),
    .rt_addr (w_rt),
    .rs_data (w_rs_data),
    .rt_data (w_rt_data),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Decode: control bundle, immediate, rt usage, branch condition and target.
  always_comb begin
    w_ctrl      = BUBBLE;
    w_valid     = 1'b1;
    w_is_branch = 1'b0;
    w_br_taken  = 1'b0;
    w_uses_rt   = 1'b0;
    w_imm       = w_imm_sext;
    w_target    = pc_in + {w_imm_sext[29:0], 2'b00};
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_uses_rt        = 1'b1;
        case (w_funct)
          F_ADD:  w_ctrl.alu_op = ALU_ADD;
          F_ADDU: w_ctrl.alu_op = ALU_ADDU;
          F_SUB:  w_ctrl.alu_op = ALU_SUB;
          F_SUBU: w_ctrl.alu_op = ALU_SUBU;
          F_AND:  w_ctrl.alu_op = ALU_AND;
          F_OR:   w_ctrl.alu_op = ALU_OR;
          F_XOR:  w_ctrl.alu_op = ALU_XOR;
          F_NOR:  w_ctrl.alu_op = ALU_NOR;
          F_SLT:  w_ctrl.alu_op = ALU_SLT;
          F_SLTU: w_ctrl.alu_op = ALU_SLTU;
          F_SLL:  w_ctrl.alu_op = ALU_SLL;
          F_SRL:  w_ctrl.alu_op = ALU_SRL;
          F_SRA:  w_ctrl.alu_op = ALU_SRA;
          F_JR: begin
            w_ctrl      = BUBBLE;
            w_uses_rt   = 1'b0;
            w_is_branch = 1'b1;
            w_br_taken  = 1'b1;
            w_target    = w_rs_data;
          end
          default: begin
            w_ctrl    = BUBBLE;
            w_uses_rt = 1'b0;
            w_valid   = 1'b0;
          end
        endcase
      end
      OP_J: begin
        w_is_branch = 1'b1;
        w_br_taken  = 1'b1;
        w_target    = {pc_in[31:28], inst_in[25:0], 2'b00};
      end
      OP_BEQ: begin
        w_is_branch = 1'b1;
        w_uses_rt   = 1'b1;
        w_br_taken  = (w_rs_data == w_rt_data);
      end
      OP_BNE: begin
        w_is_branch = 1'b1;
        w_uses_rt   = 1'b1;
        w_br_taken  = (w_rs_data != w_rt_data);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        case (w_op)
          OP_ADDI:  w_ctrl.alu_op = ALU_ADD;
          OP_ADDIU: w_ctrl.alu_op = ALU_ADDU;
          OP_SLTI:  w_ctrl.alu_op = ALU_SLT;
          default:  w_ctrl.alu_op = ALU_SLTU;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm            = {16'd0, inst_in[15:0]};
        case (w_op)
          OP_ANDI: w_ctrl.alu_op = ALU_AND;
          OP_ORI:  w_ctrl.alu_op = ALU_OR;
          default: w_ctrl.alu_op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_LUI;
        w_imm            = {inst_in[15:0], 16'd0};
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
        w_uses_rt        = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
  end

  // Load-use hazard: the lw result is not available until after EX/MEM.
  assign w_stall = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == w_rs) || ((ex_rt == w_rt) && w_uses_rt));

  // Stage arbitration: stall beats exception beats branch; a squashed
  // instruction raises neither and only becomes a bubble.
  always_comb begin
    w_except = 1'b0;
    w_br     = 1'b0;
    w_bubble = 1'b1;
    if (w_stall) begin
      w_bubble = 1'b1;
    end else if (r_squash) begin
      w_bubble = 1'b1;
    end else if (!w_valid) begin
      w_except = 1'b1;
    end else if (w_is_branch) begin
      w_br = w_br_taken;
    end else begin
      w_bubble = 1'b0;
    end
  end

  assign hold_pc   = w_stall;
  assign hold_if   = w_stall;
  assign br        = w_br;
  assign except    = w_except;
  assign pc_branch = w_target;

  // Squash flag and faulting PC; squash survives stalls until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_squash <= 1'b0;
      r_epc    <= 32'd0;
    end else if (!w_stall) begin
      if (r_squash) begin
        r_squash <= 1'b0;
      end else if (w_except) begin
        r_squash <= 1'b1;
        r_epc    <= pc_in - 32'd4;
      end
    end
  end

  // ID/EX pipeline register: either the decoded instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= BUBBLE;
      r_pc      <= 32'd0;
      r_rs_data <= 32'd0;
      r_rt_data <= 32'd0;
      r_imm     <= 32'd0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_rd      <= 5'd0;
    end else if (w_bubble) begin
      r_ctrl    <= BUBBLE;
      r_pc      <= 32'd0;
      r_rs_data <= 32'd0;
      r_rt_data <= 32'd0;
      r_imm     <= 32'd0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_rd      <= 5'd0;
    end else begin
      r_ctrl    <= w_ctrl;
      r_pc      <= pc_in;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= w_imm;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_rd      <= w_rd;
    end
  end

  assign epc           = r_epc;
  assign id_pc         = r_pc;
  assign id_rs_data    = r_rs_data;
  assign id_rt_data    = r_rt_data;
  assign id_imm        = r_imm;
  assign id_rs         = r_rs;
  assign id_rt         = r_rt;
  assign id_rd         = r_rd;
  assign id_alu_op     = r_ctrl.alu_op;
  assign id_reg_write  = r_ctrl.reg_write;
  assign id_mem_read   = r_ctrl.mem_read;
  assign id_mem_write  = r_ctrl.mem_write;
  assign id_mem_to_reg = r_ctrl.mem_to_reg;
  assign id_alu_src    = r_ctrl.alu_src;
  assign id_reg_dst    = r_ctrl.reg_dst;

endmodule
